// File: rtl/request_sequencer_if.sv
// request_sequencer_if: byte receive, sensor dispatch and byte transmit signals of the request sequencer
interface request_sequencer_if;
  logic rx_done;
  logic [7:0] rx_data;
  logic sensor_start;
  logic [7:0] sensor_request;
  logic [31:0] device_selector;
  logic sensor_done;
  logic sensor_error;
  logic [7:0] sensor_code;
  logic [7:0] sensor_data;
  logic tx_busy;
  logic tx_start;
  logic [7:0] tx_data;
  modport slave (
    input rx_done, rx_data, sensor_done, sensor_error, sensor_code, sensor_data, tx_busy,
    output sensor_start, sensor_request, device_selector, tx_start, tx_data
  );
  modport master (
    output rx_done, rx_data, sensor_done, sensor_error, sensor_code, sensor_data, tx_busy,
    input sensor_start, sensor_request, device_selector, tx_start, tx_data
  );
endinterface

// File: rtl/request_sequencer.sv
// request_sequencer: assembles 2-byte client frames, runs one sensor transaction at a time, returns code/data
module request_sequencer #(
  parameter int unsigned BYTE_GAP_CYCLES = 5_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter logic [2:0] BASE_ADDR = 3'b001
) (
  input  logic clock,
  input  logic reset_n,
  request_sequencer_if.slave bus,
  output logic busy,
  output logic [7:0] dropped_count,
  output logic [2:0] debug_state
);
  typedef enum logic [2:0] {
    IDLE = 3'd0, WAIT_ADDR = 3'd1, DISPATCH = 3'd2, WAIT_SENSOR = 3'd3,
    SEND_CODE = 3'd4, SEND_DATA = 3'd5, WAIT_TX = 3'd6
  } state_t;
  state_t state, state_n;
  logic [7:0] request, request_n, address, address_n, code, code_n, data, data_n;
  logic [7:0] sensor_request_n, tx_data_n, dropped_n;
  logic [31:0] gap_cnt, gap_cnt_n, to_cnt, to_cnt_n, selector_n;
  logic sensor_start_n, tx_start_n, drop, tx_ready;
  // tx_start is high exactly during the guard cycle, so it masks tx_busy there
  assign tx_ready = !bus.tx_start && !bus.tx_busy;
  assign busy = state != IDLE;
  assign debug_state = state;
  always_comb begin
    state_n = state;
    request_n = request;
    address_n = address;
    code_n = code;
    data_n = data;
    gap_cnt_n = gap_cnt;
    to_cnt_n = to_cnt;
    selector_n = bus.device_selector;
    sensor_request_n = bus.sensor_request;
    tx_data_n = bus.tx_data;
    sensor_start_n = 1'b0;
    tx_start_n = 1'b0;
    drop = bus.rx_done && state != IDLE && state != WAIT_ADDR;
    case (state)
      IDLE: if (bus.rx_done) begin
        request_n = bus.rx_data;
        gap_cnt_n = '0;
        state_n = WAIT_ADDR;
      end
      WAIT_ADDR: if (bus.rx_done) begin
        address_n = bus.rx_data;
        state_n = DISPATCH;
      end else if (gap_cnt == BYTE_GAP_CYCLES - 1) begin
        drop = 1'b1;
        state_n = IDLE;
      end else gap_cnt_n = gap_cnt + 32'd1;
      DISPATCH: if (address[7:5] == BASE_ADDR) begin
        selector_n = 32'd1 << address[4:0];
        sensor_request_n = request;
        sensor_start_n = 1'b1;
        to_cnt_n = '0;
        state_n = WAIT_SENSOR;
      end else begin
        code_n = 8'hFF;
        data_n = address;
        state_n = SEND_CODE;
      end
      WAIT_SENSOR: if (bus.sensor_done || to_cnt == TIMEOUT_CYCLES - 1) begin
        code_n = !bus.sensor_done ? 8'hFE : bus.sensor_error ? 8'hFD : bus.sensor_code;
        data_n = (!bus.sensor_done || bus.sensor_error) ? 8'h00 : bus.sensor_data;
        selector_n = '0;
        state_n = SEND_CODE;
      end else to_cnt_n = to_cnt + 32'd1;
      SEND_CODE: if (tx_ready) begin
        tx_start_n = 1'b1;
        tx_data_n = code;
        state_n = SEND_DATA;
      end
      SEND_DATA: if (tx_ready) begin
        tx_start_n = 1'b1;
        tx_data_n = data;
        state_n = WAIT_TX;
      end
      WAIT_TX: if (tx_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    dropped_n = (drop && dropped_count != 8'hFF) ? dropped_count + 8'd1 : dropped_count;
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      request <= '0;
      address <= '0;
      code <= '0;
      data <= '0;
      gap_cnt <= '0;
      to_cnt <= '0;
      dropped_count <= '0;
      bus.device_selector <= '0;
      bus.sensor_request <= '0;
      bus.sensor_start <= 1'b0;
      bus.tx_start <= 1'b0;
      bus.tx_data <= '0;
    end else begin
      state <= state_n;
      request <= request_n;
      address <= address_n;
      code <= code_n;
      data <= data_n;
      gap_cnt <= gap_cnt_n;
      to_cnt <= to_cnt_n;
      dropped_count <= dropped_n;
      bus.device_selector <= selector_n;
      bus.sensor_request <= sensor_request_n;
      bus.sensor_start <= sensor_start_n;
      bus.tx_start <= tx_start_n;
      bus.tx_data <= tx_data_n;
    end
  end
endmodule

// File: tb/tb_request_sequencer.sv
// tb_request_sequencer: randomized frames against a frame-level response model with queue-based scoreboard
module tb_request_sequencer;
  localparam int G = 20;
  localparam int T = 50;
  typedef struct {logic [31:0] sel; logic [7:0] req; int at; int len;} start_t;
  typedef struct {int delay; logic err; logic [7:0] code; logic [7:0] data;} sens_t;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic busy;
  logic [7:0] dropped_count;
  logic [2:0] debug_state;
  logic tx_hold = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int model_drops = 0;
  int tx_cnt = 0;
  logic [7:0] q_tx[$];
  logic [7:0] q_drop[$];
  start_t q_start[$];
  sens_t q_sens[$];
  request_sequencer_if bus();
  request_sequencer #(.BYTE_GAP_CYCLES(G), .TIMEOUT_CYCLES(T), .BASE_ADDR(3'b001)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus.slave),
    .busy(busy), .dropped_count(dropped_count), .debug_state(debug_state)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask
  task automatic bump();
    model_drops = model_drops == 255 ? 255 : model_drops + 1;
  endtask
  // monitor: pops expectations whenever the DUT starts a sensor, sends a byte or finishes a frame
  initial begin
    logic prev_busy, sel_on;
    logic [31:0] cur_sel;
    int sel_len, exp_len;
    start_t s;
    prev_busy = 0; sel_on = 0; cur_sel = 0; sel_len = 0; exp_len = 0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        check("reset_outputs", 32'({bus.sensor_start, bus.tx_start, busy, bus.sensor_request,
                                    bus.tx_data, dropped_count, debug_state}), 32'd0);
        check("reset_selector", bus.device_selector, 32'd0);
        prev_busy = 0;
        sel_on = 0;
        continue;
      end
      if (bus.sensor_start) begin
        if (q_start.size() == 0) begin
          checks++; errors++;
          $display("FAIL sensor_start unexpected pulse at cycle %0d, required none", cyc);
        end else begin
          s = q_start.pop_front();
          check("start_cycle", 32'(cyc), 32'(s.at));
          check("selector", bus.device_selector, s.sel);
          check("sensor_request", 32'(bus.sensor_request), 32'(s.req));
          cur_sel = s.sel; exp_len = s.len; sel_len = 0; sel_on = 1;
        end
      end
      if (sel_on) begin
        if (bus.device_selector == 32'd0) begin
          check("selector_cycles", 32'(sel_len), 32'(exp_len));
          sel_on = 0;
        end else begin
          check("selector_hold", bus.device_selector, cur_sel);
          sel_len++;
        end
      end else check("selector_idle", bus.device_selector, 32'd0);
      if (bus.tx_start) begin
        if (q_tx.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_start unexpected byte %h, required none", bus.tx_data);
        end else check("tx_data", 32'(bus.tx_data), 32'(q_tx.pop_front()));
        check("tx_selector_clear", bus.device_selector, 32'd0);
      end
      if (prev_busy && !busy) begin
        if (q_drop.size() == 0) begin
          checks++; errors++;
          $display("FAIL frame_end unexpected end of transaction, required none");
        end else check("dropped_count", 32'(dropped_count), 32'(q_drop.pop_front()));
      end
      prev_busy = busy;
    end
  end
  // transmitter: busy for a random span starting the cycle after each tx_start
  initial begin
    logic last_busy, prev_dut;
    last_busy = 0; prev_dut = 0; bus.tx_busy = 0;
    forever begin
      @(negedge clock);
      if (bus.tx_start) begin
        checks++;
        if (last_busy || tx_cnt > 0) begin
          errors++;
          $display("FAIL tx_handshake start while transmitter busy cnt=%0d busy=%0b, required idle", tx_cnt, last_busy);
        end
      end
      if (prev_dut && !busy && reset_n) begin
        checks++;
        if (tx_cnt > 0) begin
          errors++;
          $display("FAIL tx_drain frame ended with %0d transmitter cycles left, required 0", tx_cnt);
        end
      end
      prev_dut = busy;
      if (tx_cnt > 0) tx_cnt--;
      bus.tx_busy = tx_cnt > 0 || tx_hold;
      last_busy = bus.tx_busy;
      if (bus.tx_start) tx_cnt = ($urandom_range(0, 9) == 0 ? 30 : int'($urandom_range(1, 6))) + 1;
    end
  end
  // sensor: answers each start after the delay queued with its frame
  initial begin
    sens_t s;
    bus.sensor_done = 0; bus.sensor_error = 0; bus.sensor_code = 0; bus.sensor_data = 0;
    forever begin
      @(negedge clock);
      if (bus.sensor_start && q_sens.size() > 0) begin
        s = q_sens.pop_front();
        repeat (s.delay) @(negedge clock);
        bus.sensor_done = 1; bus.sensor_error = s.err; bus.sensor_code = s.code; bus.sensor_data = s.data;
        @(negedge clock);
        bus.sensor_done = 0;
        bus.sensor_error = 1'($urandom);
        bus.sensor_code = 8'($urandom);
        bus.sensor_data = 8'($urandom);
      end
    end
  end
  // one client frame; gap > G sends only the request byte; stray 1/2 injects a byte that many cycles after the address
  task automatic frame(input logic [7:0] req, input logic [7:0] addr, input int gap, input int delay,
                       input logic err, input logic [7:0] code, input logic [7:0] data,
                       input int stray, input bit hold);
    int n, je;
    bus.rx_done = 1; bus.rx_data = req;
    if (gap > G) begin
      bump();
      q_drop.push_back(8'(model_drops));
      @(negedge clock); bus.rx_done = 0;
    end else begin
      for (int i = 1; i < gap; i++) begin
        @(negedge clock); bus.rx_done = 0; bus.rx_data = 8'($urandom);
      end
      @(negedge clock); bus.rx_done = 1; bus.rx_data = addr;
      if (addr[7:5] == 3'b001) begin
        je = delay < T ? delay : T - 1;
        q_start.push_back('{32'd1 << addr[4:0], req, cyc + 2, je + 1});
        q_sens.push_back('{delay, err, code, data});
        q_tx.push_back(delay >= T ? 8'hFE : err ? 8'hFD : code);
        q_tx.push_back(delay >= T || err ? 8'h00 : data);
      end else begin
        q_tx.push_back(8'hFF);
        q_tx.push_back(addr);
      end
      if (stray != 0) bump();
      q_drop.push_back(8'(model_drops));
      tx_hold = hold;
      for (int i = 1; i <= 2; i++) begin
        @(negedge clock); bus.rx_done = stray == i; bus.rx_data = 8'($urandom);
      end
      @(negedge clock); bus.rx_done = 0;
      if (hold) begin
        repeat (27) @(negedge clock);
        tx_hold = 0;
      end
    end
    n = 0;
    while (busy && n < 1000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 1000) begin
      checks++; errors++;
      $display("FAIL busy_timeout busy still high after %0d cycles, required low", n);
    end
    repeat ($urandom_range(0, 3)) @(negedge clock);
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog simulation did not finish, required completion");
    $fatal(1);
  end
  initial begin
    logic [7:0] addr;
    int r, gap;
    bus.rx_done = 0; bus.rx_data = 0;
    repeat (3) @(negedge clock);
    reset_n = 1;
    frame(8'h01, 8'h20, 3, 30, 0, 8'h01, 8'h37, 0, 0);
    frame(8'h03, 8'h55, 1, 10, 0, 8'h00, 8'h00, 0, 0);
    frame(8'h01, 8'h20, 2, T + 2, 0, 8'h11, 8'h22, 0, 0);
    frame(8'h01, 8'h21, 2, T - 1, 0, 8'h33, 8'h44, 0, 0);
    frame(8'h05, 8'h3F, 2, T, 0, 8'h55, 8'h66, 0, 0);
    frame(8'h01, 8'h20, 1, 20, 1, 8'h01, 8'h12, 0, 0);
    frame(8'h01, 8'h20, G + 1, 1, 0, 8'h00, 8'h00, 0, 0);
    frame(8'h01, 8'h20, 4, 25, 0, 8'h01, 8'h37, 2, 0);
    frame(8'h02, 8'h3A, G, 15, 0, 8'h09, 8'h08, 0, 1);
    frame(8'h02, 8'h40, 1, 5, 0, 8'h00, 8'h00, 1, 0);
    for (int f = 0; f < 40; f++) begin
      r = $urandom_range(0, 9);
      gap = r == 0 ? G + 1 : r == 1 ? G : int'($urandom_range(1, 4));
      addr = $urandom_range(0, 3) == 0 ? 8'($urandom) : {3'b001, 5'($urandom)};
      frame(8'($urandom), addr, gap, $urandom_range(1, T + 3), 1'($urandom_range(0, 3) == 0),
            8'($urandom), 8'($urandom), $urandom_range(0, 2), $urandom_range(0, 7) == 0);
    end
    for (int f = 0; f < 260; f++) frame(8'($urandom), 8'h20, G + 1, 1, 0, 8'h00, 8'h00, 0, 0);
    // reset while waiting on the sensor: no response may follow
    bus.rx_done = 1; bus.rx_data = 8'h07;
    @(negedge clock); bus.rx_done = 0;
    @(negedge clock); bus.rx_done = 1; bus.rx_data = 8'h24;
    q_start.push_back('{32'h10, 8'h07, cyc + 2, 0});
    q_sens.push_back('{40, 1'b0, 8'h01, 8'h02});
    @(negedge clock); bus.rx_done = 0;
    repeat (10) @(negedge clock);
    reset_n = 0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1;
    model_drops = 0;
    repeat (60) @(negedge clock);
    frame(8'h01, 8'h20, 2, 12, 0, 8'hA5, 8'h5A, 2, 0);
    repeat (5) @(negedge clock);
    check("left_tx", 32'(q_tx.size()), 32'd0);
    check("left_start", 32'(q_start.size()), 32'd0);
    check("left_drop", 32'(q_drop.size()), 32'd0);
    check("left_sensor", 32'(q_sens.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
